fir_coef_ctrl: RTL
==================

Name: fir_coef_ctrl

Overview:
- Coefficient-reload and stream-gating controller placed in front of the 128-tap FIR MAC (firmac).
- Forwards the upstream sample stream to firmac `din`/`din_vld`.
- Accepts a new coefficient set over a valid/ready port and writes it into the filter's shadow coefficient bank while filtering continues.
- Then stalls input, drains all in-flight samples and atomically swaps the active bank, so no output ever mixes old and new coefficients.

Parameters:
- TAPS, 128, number of coefficients per set.
- BW, 16, sample and coefficient width.
- AW, 7, coefficient address width; must satisfy 2^AW >= TAPS.
- INFLIGHT_MAX, 15, maximum samples accepted but not yet returned on `dout_vld`.
- CW, 4, in-flight counter width; must hold INFLIGHT_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cfg_start  in  1  pulse: begin loading a new coefficient set.
- cfg_abort  in  1  pulse: abandon the load in progress.
- cfg_data  in  BW  coefficient value, tap 0 first.
- cfg_vld  in  1  `cfg_data` valid.
- cfg_rdy  out  1  controller accepts `cfg_data`.
- s_din  in  BW  upstream sample.
- s_vld  in  1  upstream sample valid.
- s_rdy  out  1  controller accepts sample.
- din  out  BW  sample to firmac.
- din_vld  out  1  sample valid to firmac.
- dout_vld  in  1  firmac result-valid, used for in-flight tracking only.
- coef_we  out  1  coefficient RAM write enable.
- coef_wbank  out  1  bank being written; always equals ~act_bank.
- coef_addr  out  AW  coefficient RAM write address.
- coef_data  out  BW  coefficient RAM write data.
- act_bank  out  1  bank firmac reads coefficients from.
- busy  out  1  high in any state other than IDLE.
- swap_done  out  1  one-cycle pulse after a bank swap.
- err  out  1  sticky flag: `dout_vld` received with zero samples in flight.

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, act_bank=0, inflight=0, idx=0, err=0. Outputs din=0, din_vld=0, coef_we=0, coef_addr=0, coef_data=0, swap_done=0. While rst is high, s_rdy=0 and cfg_rdy=0. Reset mid-load or mid-drain discards everything; act_bank returns to 0.
- Sample path:
  - accept = s_vld & s_rdy.
  - din and din_vld are registered: din_vld <= accept, din <= s_din when accept, else din holds. Latency is 1 cycle.
  - s_rdy = (state is IDLE or LOAD) & (inflight < INFLIGHT_MAX | dout_vld). s_rdy is combinational.
- In-flight counter:
  - +1 on accept, -1 on dout_vld; both in the same cycle leaves it unchanged.
  - The counter includes the sample held in the din register.
  - dout_vld with inflight=0 and no accept in that cycle sets err; the counter stays at 0.
- States:
  - IDLE: cfg_rdy=0. cfg_start -> LOAD with idx=0.
  - LOAD: cfg_rdy=1.
    - Each cfg_vld & cfg_rdy produces, registered one cycle later: coef_we=1, coef_addr=idx, coef_data=cfg_data. idx then increments.
    - Accepting the word at idx=TAPS-1 -> DRAIN.
    - cfg_abort has priority over a same-cycle coefficient beat: -> IDLE with no write and no swap. The shadow bank is left partial; act_bank is unchanged.
  - DRAIN: cfg_rdy=0, s_rdy=0. When inflight=0 and coef_we=0 -> SWAP. cfg_abort is ignored.
  - SWAP (one cycle): act_bank toggles at exit; swap_done=1 in the following cycle; -> IDLE.
- cfg_start outside IDLE is ignored. cfg_abort outside LOAD is ignored.
- cfg_start and cfg_vld in the same cycle: the data is not accepted, because cfg_rdy=0 in IDLE.
- Gaps in cfg_vld are allowed; idx holds.
- coef_wbank is combinational ~act_bank, so every write in a load targets the bank that is inactive at that time.
- coef_we is high only the cycle after a beat is accepted.
- Samples keep streaming during LOAD using the old coefficients.

Test Plan:
1. Reset, then 20 samples with s_vld=1 constantly and a model of 5-cycle firmac latency -> din_vld follows s_vld by 1 cycle; inflight peaks at 6; s_rdy stays 1; act_bank=0; err=0.
2. cfg_start, then 128 contiguous coefficients 0x0001..0x0080 with streaming active -> coef_we high 128 cycles; coef_addr 0..127; coef_wbank=1; DRAIN drops s_rdy; swap after the last dout_vld; act_bank=1; swap_done pulses once; s_rdy returns 1 the cycle after SWAP.
3. Load interrupted by cfg_abort after 50 beats -> state returns to IDLE; exactly 50 writes occurred; act_bank unchanged; no swap_done; a second full load then swaps normally.
4. Stall firmac: 15 samples accepted with no dout_vld -> s_rdy=0 at inflight=15. A cycle with a single dout_vld and s_vld=1 -> accept allowed; count stays 15.
5. Spurious dout_vld with inflight=0 -> err=1 and stays 1 until rst. rst asserted mid-DRAIN -> next cycle all outputs at reset values; act_bank=0.
6. cfg_vld toggled 1/0 per cycle during LOAD -> 128 writes spread over 255 cycles with addresses in order; cfg_start pulses during LOAD/DRAIN have no effect.

Source files
------------

// File: rtl/fir_coef_ctrl.sv
// Coefficient-reload and stream-gating controller in front of the firmac FIR MAC.
// Streams samples, fills the shadow coefficient bank, then drains and swaps banks atomically.
module fir_coef_ctrl #(
    parameter int TAPS         = 128,
    parameter int BW           = 16,
    parameter int AW           = 7,
    parameter int INFLIGHT_MAX = 15,
    parameter int CW           = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cfg_start,
    input  logic          cfg_abort,
    input  logic [BW-1:0] cfg_data,
    input  logic          cfg_vld,
    output logic          cfg_rdy,
    input  logic [BW-1:0] s_din,
    input  logic          s_vld,
    output logic          s_rdy,
    output logic [BW-1:0] din,
    output logic          din_vld,
    input  logic          dout_vld,
    output logic          coef_we,
    output logic          coef_wbank,
    output logic [AW-1:0] coef_addr,
    output logic [BW-1:0] coef_data,
    output logic          act_bank,
    output logic          busy,
    output logic          swap_done,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, SWAP} state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] inflight;
    logic [AW-1:0] idx;
    logic          accept;
    logic          beat;
    logic          last_beat;

    // A coefficient beat is dropped when an abort arrives in the same cycle.
    assign accept     = s_vld & s_rdy;
    assign beat       = cfg_vld & cfg_rdy & ~cfg_abort;
    assign last_beat  = beat & (idx == AW'(TAPS - 1));
    assign coef_wbank = ~act_bank;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (cfg_start) next_state = LOAD;
            LOAD: begin
                if (cfg_abort) begin
                    next_state = IDLE;
                end else if (last_beat) begin
                    next_state = DRAIN;
                end
            end
            // The final coefficient write must land before the banks swap.
            DRAIN:   if ((inflight == '0) && !coef_we) next_state = SWAP;
            SWAP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        s_rdy   = 1'b0;
        cfg_rdy = 1'b0;
        busy    = 1'b0;
        if (!rst) begin
            s_rdy   = ((state == IDLE) || (state == LOAD)) &&
                      ((inflight < CW'(INFLIGHT_MAX)) || dout_vld);
            cfg_rdy = (state == LOAD);
            busy    = (state != IDLE);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            din     <= '0;
            din_vld <= 1'b0;
        end else begin
            din_vld <= accept;
            if (accept) din <= s_din;
        end
    end

    // The count covers the sample sitting in the din register as well as those inside firmac.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight <= '0;
            err      <= 1'b0;
        end else if (accept && !dout_vld) begin
            inflight <= inflight + CW'(1);
        end else if (!accept && dout_vld) begin
            if (inflight == '0) begin
                err <= 1'b1;
            end else begin
                inflight <= inflight - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            coef_we   <= 1'b0;
            coef_addr <= '0;
            coef_data <= '0;
        end else begin
            coef_we <= beat;
            if ((state == IDLE) && cfg_start) begin
                idx <= '0;
            end else if (beat) begin
                idx       <= idx + AW'(1);
                coef_addr <= idx;
                coef_data <= cfg_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            act_bank  <= 1'b0;
            swap_done <= 1'b0;
        end else begin
            swap_done <= (state == SWAP);
            if (state == SWAP) act_bank <= ~act_bank;
        end
    end

endmodule
